// File: rtl/gate_count_pkg.sv
// Shared definitions for the gated event-counter controller: state
// encoding and default widths.
package gate_count_pkg;

   localparam int GATE_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/event_counter.sv
// Saturating event counter with a sticky overflow flag. A synchronous
// clear beats enable; an increment at full scale sets ovf and leaves the
// count unchanged.
module event_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Count enabled increments, saturating at full scale.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (enable && inc) begin
         if (count == CNT_MAX) begin
            ovf <= 1'b1;
         end else begin
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/gate_count_ctrl.sv
// Gated event-counter controller: on an accepted start, clear and arm the
// event counter, count rising edges of event_in for gate_reg cycles, then
// latch the count and overflow and present them under a valid/ack handshake.
//
// Handshake: result_valid rises on entry to DONE and stays high until a cycle
// with result_ack=1; result_valid is low on the following cycle. result and
// overflow are only meaningful while result_valid=1. A start in DONE is taken
// only together with result_ack, which goes straight to ARM with no idle gap.
module gate_count_ctrl
   import gate_count_pkg::*;
#(
   parameter int GATE_W = GATE_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              event_in,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              overflow,
   output logic              result_valid,
   input  logic              result_ack,
   output state_t            dbg_state
);

   localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic [GATE_W-1:0] gate_reg;
   logic [GATE_W-1:0] timer;
   logic              gate_end;
   logic              prev_evt;
   logic              evt_edge;
   logic              cnt_clear;
   logic              cnt_en;
   logic [CNT_W-1:0]  cnt;
   logic              cnt_ovf;
   logic              cnt_at_max;

   assign gate_end   = (state == GATE) && (timer == (gate_reg - GATE_ONE));
   assign evt_edge   = event_in & ~prev_evt;
   assign cnt_clear  = (state == ARM);
   assign cnt_en     = (state == GATE);
   assign cnt_at_max = (cnt == CNT_MAX);
   assign dbg_state  = state;

   // Next-state logic and start acceptance.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM: begin
            state_nxt = GATE;
         end
         GATE: begin
            if (gate_end) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (result_ack) begin
               if (start) begin
                  accept    = 1'b1;
                  state_nxt = ARM;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register plus registered status outputs decoded from next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         busy         <= (state_nxt == ARM) || (state_nxt == GATE);
         result_valid <= (state_nxt == DONE);
      end
   end

   // Capture the gate length on an accepted start; zero means one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_reg <= '0;
      end else if (accept) begin
         gate_reg <= (gate_len == '0) ? GATE_ONE : gate_len;
      end
   end

   // Gate timer: cleared while armed, counts each GATE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= '0;
      end else if (state == ARM) begin
         timer <= '0;
      end else if (state == GATE) begin
         timer <= timer + GATE_ONE;
      end
   end

   // Previous event level for rising-edge detection, tracked in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_evt <= 1'b0;
      end else begin
         prev_evt <= event_in;
      end
   end

   // Latch result on the last GATE cycle, folding in an edge seen that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= '0;
         overflow <= 1'b0;
      end else if (gate_end) begin
         result   <= (evt_edge && !cnt_at_max) ? (cnt + CNT_ONE) : cnt;
         overflow <= cnt_ovf | (evt_edge & cnt_at_max);
      end
   end

   event_counter #(
      .CNT_W (CNT_W)
   ) u_event_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .inc    (evt_edge),
      .count  (cnt),
      .ovf    (cnt_ovf)
   );

endmodule

// File: tb/tb_gate_count_ctrl.sv
// Testbench for gate_count_ctrl: a default-width instance and a 4-bit count
// instance driven by the same stimulus, with expected results queued when a
// measurement is started and compared when it completes.
module tb_gate_count_ctrl;
   import gate_count_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] gate_len;
   logic        event_in;
   logic        result_ack;

   logic        busy, overflow, result_valid;
   logic [15:0] result;
   state_t      dbg_state;

   logic        busy_s, overflow_s, result_valid_s;
   logic [3:0]  result_s;
   state_t      dbg_state_s;

   int checks   = 0;
   int failures = 0;

   logic [16:0] exp_q[$];
   logic [4:0]  exp_sq[$];

   gate_count_ctrl #(.GATE_W(16), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .gate_len(gate_len),
      .event_in(event_in), .busy(busy), .result(result), .overflow(overflow),
      .result_valid(result_valid), .result_ack(result_ack), .dbg_state(dbg_state)
   );

   gate_count_ctrl #(.GATE_W(16), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .start(start), .gate_len(gate_len),
      .event_in(event_in), .busy(busy_s), .result(result_s), .overflow(overflow_s),
      .result_valid(result_valid_s), .result_ack(result_ack), .dbg_state(dbg_state_s)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: count rising edges during GATE cycles k=2..n+1 after start,
   // saturating at 2^w-1 with sticky overflow. Returns {ovf, count[15:0]}.
   function automatic logic [16:0] model(input logic [63:0] mask, input int n, input int w);
      int cnt;
      int mx;
      bit ovf;
      cnt = 0;
      ovf = 1'b0;
      mx  = (1 << w) - 1;
      for (int k = 2; k <= n + 1; k++) begin
         if (mask[k] && !mask[k-1]) begin
            if (cnt == mx) ovf = 1'b1;
            else cnt++;
         end
      end
      return {ovf, 16'(cnt)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input logic [63:0] mask, input int glen);
      logic [16:0] e;
      int n;
      n = (glen == 0) ? 1 : glen;
      e = model(mask, n, 16);
      exp_q.push_back(e);
      e = model(mask, n, 4);
      exp_sq.push_back({e[16], e[3:0]});
   endtask

   // Start a measurement (optionally with ack in the same cycle); mask bit k
   // is event_in during cycle start+k. gate_len is scrambled after the start.
   task automatic drive_measure(input int glen, input logic [63:0] mask, input bit with_ack,
                                output int valid_at, output int busy_cnt, output bit arm_ok);
      int n;
      n          = ((glen == 0) ? 1 : glen) + 4;
      gate_len   = 16'(glen);
      start      = 1'b1;
      result_ack = with_ack;
      event_in   = mask[0];
      valid_at   = -1;
      busy_cnt   = 0;
      arm_ok     = 1'b0;
      for (int k = 1; k <= n; k++) begin
         tick();
         start      = 1'b0;
         result_ack = 1'b0;
         gate_len   = 16'($urandom_range(0, 65535));
         event_in   = mask[k];
         if (k == 1) arm_ok = (dbg_state == ARM) && busy && !result_valid;
         if (busy) busy_cnt++;
         if (result_valid && valid_at < 0) valid_at = k;
      end
      event_in = 1'b0;
   endtask

   task automatic do_ack();
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; gate_len = '0; event_in = 1'b0; result_ack = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", result_valid); end
      checks++; if (result !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_result: got %0d/%b want 0/0", result, overflow); end
      tick();
      checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin failures++; $display("FAIL idle_hold: state %0d busy %b want IDLE/0", dbg_state, busy); end
   endtask

   task automatic test_basic_count();
      logic [63:0] mask;
      logic [16:0] e;
      logic [4:0]  es;
      int va, bc;
      bit arm;
      mask = '0;
      for (int k = 2; k < 64; k += 2) mask[k] = 1'b1;
      push_expected(mask, 10);
      drive_measure(10, mask, 1'b0, va, bc, arm);
      e = exp_q.pop_front();
      es = exp_sq.pop_front();
      checks++; if (va !== 12) begin failures++; $display("FAIL basic_latency: got %0d want 12", va); end
      checks++; if (bc !== 11) begin failures++; $display("FAIL basic_busy_cycles: got %0d want 11", bc); end
      checks++; if (!arm) begin failures++; $display("FAIL basic_arm: got state %0d want ARM one cycle after start", dbg_state); end
      checks++; if (result !== e[15:0] || overflow !== e[16]) begin failures++; $display("FAIL basic_result: got %0d/%b want %0d/%b", result, overflow, e[15:0], e[16]); end
      checks++; if (result_s !== es[3:0] || overflow_s !== es[4]) begin failures++; $display("FAIL basic_result_w4: got %0d/%b want %0d/%b", result_s, overflow_s, es[3:0], es[4]); end
      do_ack();
      checks++; if (result_valid !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL basic_ack: valid %b state %0d want 0/IDLE", result_valid, dbg_state); end
      checks++; if (result !== e[15:0]) begin failures++; $display("FAIL basic_hold_idle: got %0d want %0d", result, e[15:0]); end
   endtask

   task automatic test_edge_boundary();
      logic [63:0] masks[2];
      logic [16:0] e;
      int va, bc;
      bit arm;
      int total;
      masks[0] = '0; masks[0][1] = 1'b1; masks[0][5] = 1'b1;  // ARM cycle, last GATE cycle
      masks[1] = '0; masks[1][2] = 1'b1; masks[1][6] = 1'b1;  // first GATE cycle, first DONE cycle
      total = 0;
      for (int r = 0; r < 2; r++) begin
         push_expected(masks[r], 4);
         drive_measure(4, masks[r], 1'b0, va, bc, arm);
         e = exp_q.pop_front();
         void'(exp_sq.pop_front());
         checks++; if (result !== e[15:0] || va !== 6) begin failures++; $display("FAIL edge_run%0d: got %0d at %0d want %0d at 6", r, result, va, e[15:0]); end
         total += int'(result);
         do_ack();
      end
      checks++; if (total !== 2) begin failures++; $display("FAIL edge_total: got %0d want 2", total); end
   endtask

   task automatic test_saturation();
      logic [63:0] mask;
      logic [16:0] e;
      logic [4:0]  es;
      int va, bc;
      bit arm;
      mask = '0;
      for (int k = 2; k <= 40; k += 2) mask[k] = 1'b1;
      push_expected(mask, 40);
      drive_measure(40, mask, 1'b0, va, bc, arm);
      e = exp_q.pop_front();
      es = exp_sq.pop_front();
      checks++; if (result_s !== es[3:0] || overflow_s !== es[4]) begin failures++; $display("FAIL sat_w4: got %0d/%b want %0d/%b", result_s, overflow_s, es[3:0], es[4]); end
      checks++; if (result !== e[15:0] || overflow !== e[16]) begin failures++; $display("FAIL sat_w16: got %0d/%b want %0d/%b", result, overflow, e[15:0], e[16]); end
      checks++; if (va !== 42) begin failures++; $display("FAIL sat_latency: got %0d want 42", va); end
      do_ack();
   endtask

   task automatic test_zero_len_handshake();
      logic [63:0] mask;
      logic [16:0] e;
      int va, bc;
      bit arm;
      mask = '0; mask[2] = 1'b1;
      push_expected(mask, 0);
      drive_measure(0, mask, 1'b0, va, bc, arm);
      e = exp_q.pop_front();
      void'(exp_sq.pop_front());
      checks++; if (va !== 3) begin failures++; $display("FAIL zero_latency: got %0d want 3", va); end
      checks++; if (bc !== 2) begin failures++; $display("FAIL zero_busy_cycles: got %0d want 2", bc); end
      checks++; if (result !== e[15:0]) begin failures++; $display("FAIL zero_result: got %0d want %0d", result, e[15:0]); end
      start = 1'b1;
      gate_len = 16'd7;
      repeat (3) tick();
      start = 1'b0;
      checks++; if (dbg_state !== DONE || result_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL start_no_ack: state %0d valid %b busy %b want DONE/1/0", dbg_state, result_valid, busy); end
      checks++; if (result !== e[15:0]) begin failures++; $display("FAIL start_no_ack_hold: got %0d want %0d", result, e[15:0]); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] mask;
      logic [16:0] e;
      int va, bc;
      bit arm;
      mask = '0; mask[2] = 1'b1; mask[4] = 1'b1;
      push_expected(mask, 3);
      drive_measure(3, mask, 1'b1, va, bc, arm);
      e = exp_q.pop_front();
      void'(exp_sq.pop_front());
      checks++; if (!arm) begin failures++; $display("FAIL b2b_arm: got state %0d valid %b want ARM/0", dbg_state, result_valid); end
      checks++; if (va !== 5 || bc !== 4) begin failures++; $display("FAIL b2b_timing: got valid@%0d busy %0d want 5/4", va, bc); end
      checks++; if (result !== e[15:0] || overflow !== e[16]) begin failures++; $display("FAIL b2b_result: got %0d/%b want %0d/%b", result, overflow, e[15:0], e[16]); end
      do_ack();
   endtask

   task automatic test_reset_mid();
      logic [63:0] mask;
      logic [16:0] e;
      int va, bc;
      bit arm;
      gate_len = 16'd20;
      start = 1'b1;
      event_in = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         start = 1'b0;
         event_in = (k == 2) || (k == 4) || (k == 6);
      end
      checks++; if (dbg_state !== GATE) begin failures++; $display("FAIL mid_in_gate: got %0d want GATE", dbg_state); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      event_in = 1'b0;
      checks++; if (dbg_state !== IDLE || busy !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_ctrl: state %0d busy %b valid %b want IDLE/0/0", dbg_state, busy, result_valid); end
      checks++; if (result !== 16'd0 || overflow !== 1'b0 || result_s !== 4'd0) begin failures++; $display("FAIL mid_reset_result: got %0d/%b want 0/0", result, overflow); end
      tick();
      mask = '0;
      push_expected(mask, 3);
      drive_measure(3, mask, 1'b0, va, bc, arm);
      e = exp_q.pop_front();
      void'(exp_sq.pop_front());
      checks++; if (result !== e[15:0] || overflow !== e[16] || va !== 5) begin failures++; $display("FAIL post_reset_run: got %0d/%b at %0d want %0d/%b at 5", result, overflow, va, e[15:0], e[16]); end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_edge_boundary();
      test_saturation();
      test_zero_len_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
